// File: rtl/rx_cmd_parser.sv
// Command-frame parser for the REF_CLK domain.
// Collects synchronised UART RX bytes into RF write / RF read / ALU op /
// ALU nop commands and presents each one as a registered parallel word with
// a valid/ready handshake. Flags bad opcodes, bad fields, inter-byte timeout
// and overrun through a one-cycle error strobe with a sticky error code.
module rx_cmd_parser #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  CMD_RDY,
  output logic                  CMD_VLD,
  output logic [1:0]            CMD_TYPE,
  output logic [ADDR_WIDTH-1:0] CMD_ADDR,
  output logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic [DATA_WIDTH-1:0] CMD_OPA,
  output logic [DATA_WIDTH-1:0] CMD_OPB,
  output logic [3:0]            CMD_FUN,
  output logic                  ERR,
  output logic [1:0]            ERR_CODE
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [DATA_WIDTH-1:0] OP_RF_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RF_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NP = DATA_WIDTH'(8'hDD);

  localparam logic [1:0] E_FIELD   = 2'b00;
  localparam logic [1:0] E_OPCODE  = 2'b01;
  localparam logic [1:0] E_TIMEOUT = 2'b10;
  localparam logic [1:0] E_OVERRUN = 2'b11;

  typedef enum logic [1:0] {
    T_RF_WR  = 2'b00,
    T_RF_RD  = 2'b01,
    T_ALU_OP = 2'b10,
    T_ALU_NP = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_WDATA,
    S_GET_OPA,
    S_GET_OPB,
    S_GET_FUN,
    S_HOLD
  } state_e;

  state_e                state_q, state_d;
  cmd_type_e             type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [3:0]            fun_q, fun_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  op_ok;
  state_e                op_state;
  cmd_type_e             op_type;
  logic                  start_frame;
  logic                  in_get;
  logic                  addr_bad;
  logic                  fun_bad;

  assign addr_bad = (RX_P_DATA >> ADDR_WIDTH) != '0;
  assign fun_bad  = (RX_P_DATA >> 4) != '0;
  assign in_get   = (state_q == S_GET_ADDR) || (state_q == S_GET_WDATA) ||
                    (state_q == S_GET_OPA)  || (state_q == S_GET_OPB)   ||
                    (state_q == S_GET_FUN);

  // Decode the current RX byte as an opcode: first state and command type.
  always_comb begin
    op_ok    = 1'b1;
    op_state = S_IDLE;
    op_type  = T_RF_WR;
    case (RX_P_DATA)
      OP_RF_WR:  begin op_state = S_GET_ADDR; op_type = T_RF_WR;  end
      OP_RF_RD:  begin op_state = S_GET_ADDR; op_type = T_RF_RD;  end
      OP_ALU_OP: begin op_state = S_GET_OPA;  op_type = T_ALU_OP; end
      OP_ALU_NP: begin op_state = S_GET_FUN;  op_type = T_ALU_NP; end
      default:   op_ok = 1'b0;
    endcase
  end

  // Next-state, field capture, handshake, timeout and error generation.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned -- that is what keeps this block from inferring latches.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    fun_d       = fun_q;
    vld_d       = vld_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    cnt_d       = '0;
    start_frame = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) start_frame = 1'b1;
      end
      S_GET_ADDR: begin
        if (RX_D_VLD) begin
          addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          if (addr_bad) begin
            err_d      = 1'b1;
            err_code_d = E_FIELD;
            state_d    = S_IDLE;
          end else if (type_q == T_RF_WR) begin
            state_d = S_GET_WDATA;
          end else begin
            state_d = S_HOLD;
            vld_d   = 1'b1;
          end
        end
      end
      S_GET_WDATA: begin
        if (RX_D_VLD) begin
          wdata_d = RX_P_DATA;
          state_d = S_HOLD;
          vld_d   = 1'b1;
        end
      end
      S_GET_OPA: begin
        if (RX_D_VLD) begin
          opa_d   = RX_P_DATA;
          state_d = S_GET_OPB;
        end
      end
      S_GET_OPB: begin
        if (RX_D_VLD) begin
          opb_d   = RX_P_DATA;
          state_d = S_GET_FUN;
        end
      end
      S_GET_FUN: begin
        if (RX_D_VLD) begin
          fun_d = RX_P_DATA[3:0];
          if (fun_bad) begin
            err_d      = 1'b1;
            err_code_d = E_FIELD;
            state_d    = S_IDLE;
          end else begin
            state_d = S_HOLD;
            vld_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (CMD_RDY) begin
          // Consumer takes the command; a byte in the same cycle is a new opcode.
          vld_d   = 1'b0;
          state_d = S_IDLE;
          if (RX_D_VLD) start_frame = 1'b1;
        end else if (RX_D_VLD) begin
          err_d      = 1'b1;
          err_code_d = E_OVERRUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; a byte arriving on the expiry cycle takes priority.
    if (in_get && !RX_D_VLD) begin
      if (cnt_q == CNT_LAST) begin
        err_d      = 1'b1;
        err_code_d = E_TIMEOUT;
        state_d    = S_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Opcode byte: start a fresh command with all fields cleared.
    if (start_frame) begin
      if (op_ok) begin
        state_d = op_state;
        type_d  = op_type;
        addr_d  = '0;
        wdata_d = '0;
        opa_d   = '0;
        opb_d   = '0;
        fun_d   = '0;
      end else begin
        err_d      = 1'b1;
        err_code_d = E_OPCODE;
        state_d    = S_IDLE;
      end
    end
  end

  // State and output registers; every output comes straight from a flop.
  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from pre-edge values; the comb block above uses blocking.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      type_q     <= T_RF_WR;
      addr_q     <= '0;
      wdata_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      fun_q      <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      fun_q      <= fun_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
    end
  end

  assign CMD_VLD   = vld_q;
  assign CMD_TYPE  = type_q;
  assign CMD_ADDR  = addr_q;
  assign CMD_WDATA = wdata_q;
  assign CMD_OPA   = opa_q;
  assign CMD_OPB   = opb_q;
  assign CMD_FUN   = fun_q;
  assign ERR       = err_q;
  assign ERR_CODE  = err_code_q;

endmodule
